fault_detect_array: RTL and testbench

Parametrised N-channel fault debounce and latch block, the generalised successor to the per-unit error detector in the power-unit board. Each channel has its own debounce length, timebase (1 us or 1 ms tick), latched/unlatched mode and trip contribution. The block produces a registered status vector, a sticky unit trip, first-fault capture and a trip event counter for the unit controller and comms.

---
 rtl/fault_pkg.sv | 33 +++
 rtl/fault_chan.sv | 69 ++++++
 rtl/fault_detect_array.sv | 85 ++++++++
 tb/tb_fault_detect_array.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fault_pkg.sv
// Shared constants for the fault detection array: trip counter width, default
// debounce delays for the power-unit fault sources and their channel mapping.
package fault_pkg;

  localparam int unsigned TRIP_CNT_W = 8;

  // Default debounce delays, in ticks of the named timebase
  localparam int unsigned DLY_IGBT_US      = 2;
  localparam int unsigned DLY_DC_OVUV_US   = 15;
  localparam int unsigned DLY_SOFT_OVUV_US = 1000;
  localparam int unsigned DLY_OTEMP_MS     = 100;
  localparam int unsigned DLY_PWR_LOSS_US  = 15;

  // Channel indices for the power-unit mapping
  localparam int unsigned CH_IGBT     = 0;
  localparam int unsigned CH_DC_OV    = 1;
  localparam int unsigned CH_DC_UV    = 2;
  localparam int unsigned CH_SOFT_OV  = 3;
  localparam int unsigned CH_SOFT_UV  = 4;
  localparam int unsigned CH_OTEMP    = 5;
  localparam int unsigned CH_PWR_LOSS = 6;

  // Index of the lowest set bit; 0 when the vector is empty
  function automatic int unsigned lowest_set(input logic [31:0] vec);
    int unsigned idx;
    idx = 0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/fault_chan.sv
// One fault channel: 2-flop synchroniser, tick-driven debounce counter,
// latched or following flag, and the registered err_info bit.
module fault_chan
  import fault_pkg::*;
#(
  parameter int unsigned      CNT_W  = 14,
  parameter logic [CNT_W-1:0] DLY    = CNT_W'(15),
  parameter bit               USE_MS = 1'b0,
  parameter bit               LATCH  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_us,
  input  logic tick_ms,
  input  logic fault_in,
  input  logic ch_en,
  input  logic clr,
  output logic err_info
);

  if (DLY == '0) begin : g_bad_dly
    $error("fault_chan: debounce delay must be non-zero");
  end

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic             flag_q;
  logic             s;
  logic             tick;
  logic             kill;
  logic             set;

  assign s    = sync_q[1];
  assign tick = USE_MS ? tick_ms : tick_us;
  // A disabled channel behaves exactly like a held clear
  assign kill = clr | ~ch_en;
  assign set  = ~kill & s & tick & (cnt_q == DLY - CNT_W'(1));

  // Synchronise the raw input, debounce it, and hold the resulting flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      flag_q   <= 1'b0;
      err_info <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], fault_in};

      if (kill || !s) begin
        cnt_q <= '0;
      end else if (tick && cnt_q != DLY) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      if (kill) begin
        flag_q <= 1'b0;
      end else if (!LATCH && !s) begin
        flag_q <= 1'b0;
      end else if (set) begin
        flag_q <= 1'b1;
      end

      // Clears also mask the output copy so a one-cycle reset_unit cannot
      // re-trip the unit from a stale err_info bit
      err_info <= flag_q & ~kill;
    end
  end

endmodule

// File: rtl/fault_detect_array.sv
// N-channel fault debounce array with sticky unit trip, first-fault capture
// and a saturating trip event counter.
module fault_detect_array
  import fault_pkg::*;
#(
  parameter int unsigned             N_CH     = 16,
  parameter int unsigned             CNT_W    = 14,
  parameter logic [N_CH*CNT_W-1:0]   DLY_VEC  = {N_CH{CNT_W'(15)}},
  parameter logic [N_CH-1:0]         TB_MS    = '0,
  parameter logic [N_CH-1:0]         LATCH_EN = '1,
  parameter logic [N_CH-1:0]         TRIP_EN  = '1,
  parameter int unsigned             ID_W     = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick_us,
  input  logic                  tick_ms,
  input  logic [N_CH-1:0]       fault_in,
  input  logic [N_CH-1:0]       ch_en,
  input  logic                  reset_unit,
  input  logic [N_CH-1:0]       clr_ch,
  output logic [N_CH-1:0]       err_info,
  output logic                  err_unit,
  output logic                  first_valid,
  output logic [ID_W-1:0]       first_id,
  output logic [TRIP_CNT_W-1:0] trip_cnt
);

  if (N_CH < 1 || N_CH > 32 || (64'd1 << ID_W) < 64'(N_CH)) begin : g_bad_cfg
    $error("fault_detect_array: N_CH must be 1..32 and fit in ID_W bits");
  end

  logic [N_CH-1:0] trip_vec;
  logic            trip_any;
  logic [ID_W-1:0] low_id;

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    fault_chan #(
      .CNT_W  (CNT_W),
      .DLY    (DLY_VEC[g*CNT_W +: CNT_W]),
      .USE_MS (TB_MS[g]),
      .LATCH  (LATCH_EN[g])
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick_us  (tick_us),
      .tick_ms  (tick_ms),
      .fault_in (fault_in[g]),
      .ch_en    (ch_en[g]),
      .clr      (reset_unit | clr_ch[g]),
      .err_info (err_info[g])
    );
  end

  assign trip_vec = err_info & TRIP_EN;
  assign trip_any = |trip_vec;
  assign low_id   = ID_W'(lowest_set(32'(trip_vec)));

  // Sticky unit trip, first-fault capture and trip event counting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_unit    <= 1'b0;
      first_valid <= 1'b0;
      first_id    <= '0;
      trip_cnt    <= '0;
    end else begin
      if (reset_unit) begin
        err_unit    <= 1'b0;
        first_valid <= 1'b0;
        first_id    <= '0;
      end else if (trip_any) begin
        err_unit <= 1'b1;
        if (!first_valid) begin
          first_valid <= 1'b1;
          first_id    <= low_id;
        end
      end

      if (!reset_unit && trip_any && !err_unit && trip_cnt != '1) begin
        trip_cnt <= trip_cnt + TRIP_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fault_detect_array.sv
// Bench for fault_detect_array: directed phase table with settled expectations,
// hand sequences for debounce restart and counter saturation, random traffic,
// and a cycle-by-cycle comparison against a behavioural model.
module tb_fault_detect_array;

  localparam int unsigned N    = 8;
  localparam int unsigned CW   = 14;
  localparam int unsigned IW   = 3;
  localparam logic [N*CW-1:0] DLYS = {14'd3, 14'd5, 14'd100, 14'd15,
                                      14'd15, 14'd3, 14'd4, 14'd2};
  localparam logic [N-1:0] MS_M    = 8'h20;
  localparam logic [N-1:0] LATCH_M = 8'hDF;
  localparam logic [N-1:0] TRIP_M  = 8'hBF;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         tick_us = 1'b0, tick_ms = 1'b0;
  logic [N-1:0] fault_in = '0, ch_en = '1, clr_ch = '0;
  logic         reset_unit = 1'b0;
  logic [N-1:0] err_info;
  logic         err_unit, first_valid;
  logic [IW-1:0] first_id;
  logic [7:0]   trip_cnt;

  fault_detect_array #(
    .N_CH(N), .CNT_W(CW), .DLY_VEC(DLYS), .TB_MS(MS_M),
    .LATCH_EN(LATCH_M), .TRIP_EN(TRIP_M), .ID_W(IW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick_us(tick_us), .tick_ms(tick_ms),
    .fault_in(fault_in), .ch_en(ch_en), .reset_unit(reset_unit), .clr_ch(clr_ch),
    .err_info(err_info), .err_unit(err_unit), .first_valid(first_valid),
    .first_id(first_id), .trip_cnt(trip_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int us_ticks = 0;

  // Behavioural model state
  int           dly[N] = '{2, 4, 3, 15, 15, 100, 5, 3};
  int           m_run[N];
  logic [N-1:0] m_p1 = '0, m_p2 = '0, m_flag = '0, m_info = '0;
  logic         m_unit = 1'b0, m_fv = 1'b0;
  logic [IW-1:0] m_id = '0;
  int           m_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a channel raises after dly ticks of uninterrupted synced input
  task automatic model_update();
    logic [N-1:0] new_flag, new_info, trip;
    logic         clear, s_old, tk, unit_new;
    trip = m_info & TRIP_M;
    for (int i = 0; i < N; i++) begin
      clear = reset_unit | clr_ch[i] | ~ch_en[i];
      s_old = m_p2[i];
      tk    = MS_M[i] ? tick_ms : tick_us;
      if (clear || !s_old) m_run[i] = 0;
      else if (tk && m_run[i] < dly[i]) m_run[i]++;
      new_flag[i] = !clear && ((LATCH_M[i] && m_flag[i]) || (s_old && m_run[i] >= dly[i]));
      new_info[i] = m_flag[i] && !clear;
    end
    m_p2   = m_p1;
    m_p1   = fault_in;
    m_flag = new_flag;
    m_info = new_info;
    unit_new = !reset_unit && (m_unit || (trip != 0));
    if (!m_unit && unit_new && m_cnt < 255) m_cnt++;
    if (reset_unit) begin
      m_fv = 1'b0;
      m_id = '0;
    end else if (trip != 0 && !m_fv) begin
      m_fv = 1'b1;
      for (int i = N - 1; i >= 0; i--) if (trip[i]) m_id = IW'(i);
    end
    m_unit = unit_new;
  endtask

  // Apply current inputs for n clocks; compare every output each cycle
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      tick_us = (cyc % 4 == 0);
      tick_ms = (cyc % 10 == 0);
      @(posedge clk);
      model_update();
      if (tick_us) us_ticks++;
      cyc++;
      @(negedge clk);
      check("cycle_model", {11'd0, err_info, err_unit, first_valid, first_id, trip_cnt},
            {11'd0, m_info, m_unit, m_fv, m_id, m_cnt[7:0]});
    end
  endtask

  typedef struct {
    logic [7:0] fault, en, clr;
    logic       rst_u;
    int         cycles;
    logic [7:0] e_info;
    logic       e_unit, e_fv;
    logic [2:0] e_id;
    logic [7:0] e_cnt;
  } phase_t;

  phase_t tbl[13];

  initial begin
    int start, found;
    for (int i = 0; i < N; i++) m_run[i] = 0;

    tbl[0]  = '{8'h01, 8'hFF, 8'h00, 1'b0,   40, 8'h01, 1'b1, 1'b1, 3'd0, 8'd1};
    tbl[1]  = '{8'h00, 8'hFF, 8'h00, 1'b1,    3, 8'h00, 1'b0, 1'b0, 3'd0, 8'd1};
    tbl[2]  = '{8'h84, 8'hFF, 8'h00, 1'b0,   30, 8'h84, 1'b1, 1'b1, 3'd2, 8'd2};
    tbl[3]  = '{8'h86, 8'hFF, 8'h00, 1'b0,   40, 8'h86, 1'b1, 1'b1, 3'd2, 8'd2};
    tbl[4]  = '{8'h00, 8'hFF, 8'h00, 1'b1,    2, 8'h00, 1'b0, 1'b0, 3'd0, 8'd2};
    tbl[5]  = '{8'h20, 8'hFF, 8'h00, 1'b0, 1030, 8'h20, 1'b1, 1'b1, 3'd5, 8'd3};
    tbl[6]  = '{8'h00, 8'hFF, 8'h00, 1'b0,    4, 8'h00, 1'b1, 1'b1, 3'd5, 8'd3};
    tbl[7]  = '{8'h40, 8'hBF, 8'h00, 1'b0,   40, 8'h00, 1'b1, 1'b1, 3'd5, 8'd3};
    tbl[8]  = '{8'h00, 8'hFF, 8'h00, 1'b1,    2, 8'h00, 1'b0, 1'b0, 3'd0, 8'd3};
    tbl[9]  = '{8'h10, 8'hFF, 8'h00, 1'b0,   80, 8'h10, 1'b1, 1'b1, 3'd4, 8'd4};
    tbl[10] = '{8'h10, 8'hFF, 8'h00, 1'b1,    1, 8'h00, 1'b0, 1'b0, 3'd0, 8'd4};
    tbl[11] = '{8'h10, 8'hFF, 8'h00, 1'b0,   80, 8'h10, 1'b1, 1'b1, 3'd4, 8'd5};
    tbl[12] = '{8'h00, 8'hFF, 8'h10, 1'b0,    2, 8'h00, 1'b1, 1'b1, 3'd4, 8'd5};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_state", {11'd0, err_info, err_unit, first_valid, first_id, trip_cnt}, 32'd0);
    rst_n = 1'b1;

    // Directed phases with settled expectations
    for (int p = 0; p < 13; p++) begin
      fault_in   = tbl[p].fault;
      ch_en      = tbl[p].en;
      clr_ch     = tbl[p].clr;
      reset_unit = tbl[p].rst_u;
      step(tbl[p].cycles);
      check($sformatf("phase%0d_info", p), 32'(err_info), 32'(tbl[p].e_info));
      check($sformatf("phase%0d_unit", p), 32'(err_unit), 32'(tbl[p].e_unit));
      check($sformatf("phase%0d_fvalid", p), 32'(first_valid), 32'(tbl[p].e_fv));
      check($sformatf("phase%0d_fid", p), 32'(first_id), 32'(tbl[p].e_id));
      check($sformatf("phase%0d_tripcnt", p), 32'(trip_cnt), 32'(tbl[p].e_cnt));
    end
    clr_ch = '0;

    // Channel 3: 14 ticks high, one low cycle, then debounce restarts
    reset_unit = 1'b1;
    step(2);
    reset_unit = 1'b0;
    fault_in = 8'h08;
    step(2);
    start = us_ticks;
    while (us_ticks - start < 14) step(1);
    fault_in = 8'h00;
    step(1);
    fault_in = 8'h08;
    start = us_ticks;
    while (us_ticks - start < 14) step(1);
    check("glitch_no_flag", 32'(err_info[3]), 32'd0);
    found = 0;
    for (int k = 0; k < 40 && found == 0; k++) begin
      step(1);
      if (err_info[3]) found = 1;
    end
    check("glitch_reflag", 32'(found), 32'd1);

    // Random traffic
    reset_unit = 1'b1;
    fault_in = '0;
    step(2);
    reset_unit = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(7) == 0) fault_in[$urandom_range(N - 1)] ^= 1'b1;
      if ($urandom_range(31) == 0) ch_en[$urandom_range(N - 1)] ^= 1'b1;
      clr_ch     = ($urandom_range(15) == 0) ? (8'h01 << $urandom_range(N - 1)) : 8'h00;
      reset_unit = ($urandom_range(63) == 0);
      step(1);
    end

    // Trip the unit 260 times; the counter must saturate
    fault_in = 8'h01;
    ch_en = '1;
    clr_ch = '0;
    for (int t = 0; t < 260; t++) begin
      reset_unit = 1'b1;
      step(1);
      reset_unit = 1'b0;
      found = 0;
      for (int k = 0; k < 40 && found == 0; k++) begin
        step(1);
        if (err_unit) found = 1;
      end
      if (found == 0) check("trip_timeout", 32'd0, 32'd1);
    end
    check("trip_cnt_sat", 32'(trip_cnt), 32'd255);
    step(5);
    check("trip_cnt_hold", 32'(trip_cnt), 32'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
